complete_arbiter: RTL and testbench

//   Completion-side responder for all functional units (alu, mult, branch, load).

---
 rtl/complete_arbiter.sv | 124 ++++++++++++
 tb/tb_complete_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/complete_arbiter.sv
// Completion arbiter: grants up to CDB_WIDTH requesting FUs per cycle in round-robin order
// and registers the granted packets onto the CDB; non-granted requesters see fu_hazard_o.

package complete_arbiter_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] dest_value;
        logic [5:0]  dispatch_allocated_prs;
        logic [4:0]  rob_entry;
    } fu_complete_packet_t;
endpackage

module complete_arbiter
    import complete_arbiter_pkg::*;
#(
    parameter int NUM_FU    = 4,
    parameter int CDB_WIDTH = 2,
    localparam int PTR_W    = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
    localparam int CNT_W    = $clog2(CDB_WIDTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                squash_i,
    input  logic [NUM_FU-1:0]   fu_complete_req_i,
    input  fu_complete_packet_t fu_pkt_i [NUM_FU],
    output logic [NUM_FU-1:0]   fu_hazard_o,
    output fu_complete_packet_t cdb_pkt_o [CDB_WIDTH],
    output logic [CNT_W-1:0]    cdb_count_o,
    output logic [31:0]         hazard_cycles_o
);

    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    fu_complete_packet_t cdb_q [CDB_WIDTH];
    fu_complete_packet_t cdb_d [CDB_WIDTH];
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         hcnt_q, hcnt_d;

    logic                arb_en;
    logic [NUM_FU-1:0]   grant;
    logic [PTR_W-1:0]    slot_src [CDB_WIDTH];
    logic [CDB_WIDTH-1:0] slot_used;
    logic [CNT_W-1:0]    n_grant;
    logic [PTR_W-1:0]    last_idx;
    logic [PTR_W-1:0]    scan_idx;

    // Squash and reset both suppress every grant, so nothing partial ever reaches the CDB.
    assign arb_en = ~squash_i & ~rst;

    // Round-robin scan: the j-th requester found starting at rr_ptr_q fills CDB slot j.
    always_comb begin
        // NOTE: every variable gets a default before the scan so no path leaves one unassigned (no latches).
        grant     = '0;
        slot_used = '0;
        n_grant   = '0;
        last_idx  = rr_ptr_q;
        scan_idx  = '0;
        for (int j = 0; j < CDB_WIDTH; j++) begin
            slot_src[j] = '0;
        end
        for (int k = 0; k < NUM_FU; k++) begin
            scan_idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_FU);
            if (arb_en && fu_complete_req_i[scan_idx] && (int'(n_grant) < CDB_WIDTH)) begin
                grant[scan_idx] = 1'b1;
                for (int j = 0; j < CDB_WIDTH; j++) begin
                    if (int'(n_grant) == j) begin
                        slot_src[j]  = scan_idx;
                        slot_used[j] = 1'b1;
                    end
                end
                last_idx = scan_idx;
                n_grant  = n_grant + CNT_W'(1);
            end
        end
    end

    assign fu_hazard_o = fu_complete_req_i & ~grant & {NUM_FU{arb_en}};

    always_comb begin
        for (int j = 0; j < CDB_WIDTH; j++) begin
            cdb_d[j] = '0;
            if (slot_used[j]) begin
                cdb_d[j]       = fu_pkt_i[slot_src[j]];
                cdb_d[j].valid = 1'b1;
            end
        end
        cnt_d = n_grant;

        rr_ptr_d = rr_ptr_q;
        if (squash_i) begin
            rr_ptr_d = '0;
        end else if (n_grant != '0) begin
            rr_ptr_d = (int'(last_idx) == NUM_FU - 1) ? '0 : last_idx + PTR_W'(1);
        end

        hcnt_d = hcnt_q;
        if (|fu_hazard_o && (hcnt_q != 32'hFFFF_FFFF)) begin
            hcnt_d = hcnt_q + 32'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < CDB_WIDTH; j++) begin
                cdb_q[j] <= '0;
            end
            cnt_q    <= '0;
            rr_ptr_q <= '0;
            hcnt_q   <= '0;
        end else begin
            for (int j = 0; j < CDB_WIDTH; j++) begin
                cdb_q[j] <= cdb_d[j];
            end
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            hcnt_q   <= hcnt_d;
        end
    end

    assign cdb_pkt_o       = cdb_q;
    assign cdb_count_o     = cnt_q;
    assign hazard_cycles_o = hcnt_q;

endmodule

// File: tb/tb_complete_arbiter.sv
// Scoreboard bench for complete_arbiter: a reference arbiter predicts hazards and CDB contents,
// plus a CDB_WIDTH=1 instance for round-robin fairness and pointer wrap.

module tb_complete_arbiter;
    import complete_arbiter_pkg::*;

    typedef struct packed {
        fu_complete_packet_t s1;
        fu_complete_packet_t s0;
        logic [1:0]          cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                squash;
    logic [3:0]          req;
    fu_complete_packet_t pkt [4];
    logic [3:0]          haz;
    fu_complete_packet_t cdb [2];
    logic [1:0]          cnt;
    logic [31:0]         hcyc;

    logic [3:0]          req1;
    fu_complete_packet_t pkt1 [4];
    logic [3:0]          haz1;
    fu_complete_packet_t cdb1 [1];
    logic [0:0]          cnt1;
    logic [31:0]         hcyc1;

    complete_arbiter #(.NUM_FU(4), .CDB_WIDTH(2)) u_dut (
        .clk(clk), .rst(rst), .squash_i(squash),
        .fu_complete_req_i(req), .fu_pkt_i(pkt), .fu_hazard_o(haz),
        .cdb_pkt_o(cdb), .cdb_count_o(cnt), .hazard_cycles_o(hcyc)
    );

    complete_arbiter #(.NUM_FU(4), .CDB_WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .squash_i(1'b0),
        .fu_complete_req_i(req1), .fu_pkt_i(pkt1), .fu_hazard_o(haz1),
        .cdb_pkt_o(cdb1), .cdb_count_o(cnt1), .hazard_cycles_o(hcyc1)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [1:0]  m_ptr   = 2'd0;
    logic [31:0] m_hcnt  = 32'd0;
    logic [3:0]  last_haz = 4'd0;
    exp_t        sb_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic fu_complete_packet_t mk_pkt(input logic [31:0] v, input logic [5:0] prs,
                                                  input logic [4:0] rob);
        fu_complete_packet_t p;
        p.valid                  = 1'b0;
        p.dest_value             = v;
        p.dispatch_allocated_prs = prs;
        p.rob_entry              = rob;
        return p;
    endfunction

    // Called at posedge+1 with inputs already applied; returns at the following posedge+1.
    task automatic step();
        exp_t       e;
        logic [3:0] g;
        logic [3:0] eh;
        logic [1:0] last;
        logic [1:0] i;
        int         n;
        e    = '0;
        g    = '0;
        n    = 0;
        last = m_ptr;
        #4;
        if (!squash) begin
            for (int k = 0; k < 4; k++) begin
                i = 2'((int'(m_ptr) + k) % 4);
                if (req[i] && n < 2) begin
                    g[i] = 1'b1;
                    if (n == 0) begin
                        e.s0       = pkt[i];
                        e.s0.valid = 1'b1;
                    end else begin
                        e.s1       = pkt[i];
                        e.s1.valid = 1'b1;
                    end
                    n++;
                    last = i;
                end
            end
        end
        e.cnt = 2'(n);
        eh    = squash ? 4'b0000 : (req & ~g);
        check("fu_hazard", 64'(haz), 64'(eh));
        sb_q.push_back(e);
        @(posedge clk);
        if (squash) m_ptr = 2'd0;
        else if (n > 0) m_ptr = (last == 2'd3) ? 2'd0 : last + 2'd1;
        if (eh != 4'b0 && m_hcnt != 32'hFFFF_FFFF) m_hcnt = m_hcnt + 32'd1;
        last_haz = eh;
        #1;
        e = sb_q.pop_front();
        check("cdb_slot0", 64'(cdb[0]), 64'(e.s0));
        check("cdb_slot1", 64'(cdb[1]), 64'(e.s1));
        check("cdb_count", 64'(cnt), 64'(e.cnt));
        check("rr_ptr", 64'(u_dut.rr_ptr_q), 64'(m_ptr));
        check("hazard_cycles", hcyc, 64'(m_hcnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order [4];
        exp_order = '{0, 3, 0, 3};

        rst    = 1'b1;
        squash = 1'b0;
        req    = 4'hF;
        req1   = 4'h0;
        for (int i = 0; i < 4; i++) begin
            pkt[i]  = mk_pkt(32'(100 + i), 6'(i), 5'(i));
            pkt1[i] = mk_pkt(32'(200 + i), 6'(i), 5'(i));
        end

        // Reset held two cycles with every FU requesting.
        @(posedge clk);
        @(posedge clk);
        #4;
        check("rst_hazard", 64'(haz), 64'(0));
        check("rst_valid0", 64'(cdb[0].valid), 64'(0));
        check("rst_valid1", 64'(cdb[1].valid), 64'(0));
        check("rst_count", 64'(cnt), 64'(0));
        check("rst_hcyc", hcyc, 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = 4'h0;

        // Fairness and wrap on the single-slot instance: FU0 and FU3 request continuously.
        req1 = 4'b1001;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            check("wrap_valid", 64'(cdb1[0].valid), 64'(1));
            check("wrap_grant", 64'(cdb1[0].rob_entry), 64'(exp_order[c]));
            if (c == 1) check("wrap_ptr", 64'(u_dut1.rr_ptr_q), 64'(0));
        end
        req1 = 4'h0;

        // Single request from FU1.
        pkt[1] = mk_pkt(32'd35, 6'd1, 5'd2);
        req    = 4'b0010;
        step();
        check("single_value", 64'(cdb[0].dest_value), 64'(35));

        // Squash overrides a full set of requests.
        req    = 4'hF;
        squash = 1'b1;
        step();
        squash = 1'b0;

        // Oversubscription: FU0/FU1 win first, FU2/FU3 hold and win next cycle.
        for (int i = 0; i < 4; i++) pkt[i] = mk_pkt(32'(1000 + i), 6'(10 + i), 5'(20 + i));
        req = 4'hF;
        step();
        req = 4'b1100;
        step();
        req = 4'h0;

        // Asynchronous reset while a broadcast is on the CDB.
        pkt[1] = mk_pkt(32'd35, 6'd1, 5'd2);
        req    = 4'b0010;
        step();
        req = 4'h0;
        #2 rst = 1'b1;
        #1;
        check("async_valid", 64'(cdb[0].valid), 64'(0));
        check("async_count", 64'(cnt), 64'(0));
        check("async_hcyc", hcyc, 64'(0));
        #2 rst = 1'b0;
        m_ptr    = 2'd0;
        m_hcnt   = 32'd0;
        last_haz = 4'd0;
        @(posedge clk);
        #1;
        check("post_rst_valid", 64'(cdb[0].valid), 64'(0));
        req = 4'b0010;
        step();
        req = 4'h0;

        // Random traffic; hazarded FUs keep request and packet stable.
        for (int c = 0; c < 60; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!last_haz[i]) begin
                    req[i]       = 1'($urandom_range(0, 1));
                    pkt[i]       = mk_pkt($urandom, 6'($urandom), 5'($urandom));
                    pkt[i].valid = 1'($urandom_range(0, 1));
                end
            end
            squash = ($urandom_range(0, 7) == 0);
            step();
        end
        squash = 1'b0;
        req    = 4'h0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
